dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (64 x 32, async read, sync write) between the
//  pipeline memory stage and a debug/loader port. Pipeline has priority; a starvation
//  counter forces a debug slot after MAX_STARVE consecutive pipeline wins. Generates
//  StallM to the pipeline and sits between Memory-stage logic and data_memory.
// PARAMETERS
//  ADDR_W      6   word address width into data_memory
//  DATA_W      32  data width
//  MAX_STARVE  4   consecutive pipeline grants tolerated while dbg_req pending (>=1)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  MemReqM     in   1       pipeline access valid this cycle (load or store)
//  MemWriteM   in   1       pipeline store when MemReqM=1
//  AddrM       in   ADDR_W  pipeline word address (ALUOutM low bits)
//  WriteDataM  in   DATA_W  pipeline store data
//  ReadDataM   out  DATA_W  mem_spo passthrough, valid when MemReqM & ~StallM
//  StallM      out  1       freeze M and earlier stages; request held stable
//  dbg_req     in   1       debug access request; addr/we/wdata stable until gnt
//  dbg_we      in   1       debug write
//  dbg_lock    in   1       keep debug ownership after current grant (burst)
//  dbg_addr    in   ADDR_W  debug word address
//  dbg_wdata   in   DATA_W  debug write data
//  dbg_gnt     out  1       combinational grant; access happens this cycle
//  dbg_ack     out  1       registered pulse, cycle after each debug grant
//  dbg_rdata   out  DATA_W  registered read data, valid with dbg_ack for reads
//  mem_a       out  ADDR_W  to data_memory a
//  mem_d       out  DATA_W  to data_memory d
//  mem_we      out  1       to data_memory we
//  mem_spo     in   DATA_W  from data_memory spo
// BEHAVIOUR
//  - FSM {PIPE, DBG}. Reset -> PIPE, starve_cnt=0, dbg_ack=0, dbg_rdata=0.
//  - While rst=1: dbg_gnt=0, mem_we=0, StallM=0 regardless of inputs.
//  - PIPE: debug wins iff dbg_req & (~MemReqM | starve_cnt==MAX_STARVE); else pipeline.
//  - DBG: entered when a granted debug access has dbg_lock=1; debug wins iff dbg_req;
//    leave to PIPE on first cycle with dbg_req=0 or a grant with dbg_lock=0.
//  - Owner drives mem_a/mem_d/mem_we; mem_we = owner's we & owner's req. No owner:
//    mem_a=AddrM, mem_we=0.
//  - StallM = MemReqM & dbg_gnt (same cycle, combinational). Stalled store must not
//    reach mem_we; it retries next cycle with identical data.
//  - starve_cnt: +1 (saturating at MAX_STARVE) when dbg_req & pipeline granted;
//    cleared on any dbg_gnt or when dbg_req=0.
//  - dbg_ack <= dbg_gnt; dbg_rdata <= mem_spo when dbg_gnt & ~dbg_we, else holds.
//  - Debug write followed next cycle by pipeline read of same address returns new
//    data (write lands at posedge). Same-cycle collision impossible: one owner.
//  - dbg_req dropped before grant: no access, no ack, counter cleared.
//  - rst asserted mid-burst: return to PIPE next cycle, pending ack discarded (0).
//  - Latency: pipeline 0 extra cycles when uncontended; debug read data 1 cycle.
// STRUCTURE
//  - Shared package: state enum {PIPE, DBG}, default widths ADDR_W/DATA_W.
//  - Single module; no sub-module (counter and FSM are small, inline).
// TESTING
//  1 Pipeline only: store 0xDEADBEEF @5, load @5 -> ReadDataM=0xDEADBEEF, StallM never 1.
//  2 Idle pipeline, debug write 0x1234 @7 -> dbg_gnt same cycle, dbg_ack next; pipeline
//    load @7 afterwards returns 0x1234.
//  3 MemReqM and dbg_req held high continuously, MAX_STARVE=4 -> pattern 4 pipeline
//    grants, 1 debug grant with StallM=1, repeating; no store lost or duplicated.
//  4 dbg_lock=1 burst of 3 reads @0..2 with MemReqM=1 -> 3 consecutive grants, StallM=1
//    for 3 cycles, dbg_rdata matches preloaded words in order, then PIPE resumes.
//  5 rst pulse during DBG burst -> next cycle StallM=0, dbg_ack=0, pipeline granted.
//  6 Stalled pipeline store during debug grant -> mem_we driven only by debug that
//    cycle; store committed exactly once on following cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Imported by the bus interface and the arbiter top.
package dmem_arbiter_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int MAX_STARVE_DEF = 4;

  typedef enum logic {
    PIPE = 1'b0,
    DBG  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between memory stage, debug port, data memory and arbiter.
// slave = arbiter side, master = surrounding environment side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
();

  logic              MemReqM;
  logic              MemWriteM;
  logic [ADDR_W-1:0] AddrM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] ReadDataM;
  logic              StallM;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_spo;

  modport slave (
    input  MemReqM, MemWriteM, AddrM, WriteDataM,
    output ReadDataM, StallM,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_ack, dbg_rdata,
    output mem_a, mem_d, mem_we,
    input  mem_spo
  );

  modport master (
    output MemReqM, MemWriteM, AddrM, WriteDataM,
    input  ReadDataM, StallM,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_ack, dbg_rdata,
    input  mem_a, mem_d, mem_we,
    output mem_spo
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline priority with a
// starvation counter that forces a debug slot; debug bursts via lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic dbg_win;
  logic pipe_gnt;

  always_comb begin
    dbg_win = 1'b0;
    if (!rst) begin
      unique case (state_q)
        PIPE: dbg_win = bus.dbg_req &
                        (~bus.MemReqM |
                         (starve_q == STARVE_MAX));
        DBG:  dbg_win = bus.dbg_req;
        default: dbg_win = 1'b0;
      endcase
    end
    pipe_gnt = ~rst & bus.MemReqM & ~dbg_win;
  end

  // Exactly one owner drives the memory port each cycle.
  always_comb begin
    bus.dbg_gnt   = dbg_win;
    bus.StallM    = bus.MemReqM & dbg_win;
    bus.ReadDataM = bus.mem_spo;
    if (dbg_win) begin
      bus.mem_a  = bus.dbg_addr;
      bus.mem_d  = bus.dbg_wdata;
      bus.mem_we = bus.dbg_we;
    end else begin
      bus.mem_a  = bus.AddrM;
      bus.mem_d  = bus.WriteDataM;
      bus.mem_we = pipe_gnt & bus.MemWriteM;
    end
  end

  always_comb begin
    state_d  = (dbg_win & bus.dbg_lock) ? DBG : PIPE;
    starve_d = starve_q;
    if (dbg_win || !bus.dbg_req) begin
      starve_d = '0;
    end else if (pipe_gnt && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
    ack_d   = dbg_win;
    rdata_d = rdata_q;
    if (dbg_win && !bus.dbg_we) begin
      rdata_d = bus.mem_spo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PIPE;
      starve_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.dbg_ack   = ack_q;
  assign bus.dbg_rdata = rdata_q;

endmodule
